// File: rtl/instr_loader.sv
// instr_loader: encodes compact addi/bne requests into RV32I words and writes them to instruction memory.
// Latency: request accepted in cycle N -> mem_we high in cycle N+1; one word every 2 cycles.
// Backpressure: o_req_ready is high only in LOAD. Optional request checking is enabled by LOADER_CHECK_EN.
module instr_loader #(
  parameter int AW     = 6,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_op,
  input  logic [4:0]        i_req_rd,
  input  logic [4:0]        i_req_rs1,
  input  logic [4:0]        i_req_rs2,
  input  logic [12:0]       i_req_imm,
  input  logic              i_req_last,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_full,
  output logic [AW:0]       o_instr_cnt,
  output logic              o_err
);

  // Memory depth expressed in the counter width, so instr_cnt+1 can be compared directly.
  localparam logic [AW:0] L_DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [AW:0]         r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_last;
  logic                r_full;
  logic                w_hs;
  logic                w_illegal;
  logic [31:0]         w_enc;
  logic [AW:0]         w_cnt_inc;
  logic                w_at_end;
  logic                w_unused_ok;

  assign w_hs      = (r_state == S_LOAD) && i_req_valid;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_at_end  = (w_cnt_inc == L_DEPTH);
  // bne never encodes imm[0]; without checking it is simply dropped.
  assign w_unused_ok = &{1'b0, i_req_imm[0]};

  // Encode the request; fields a given opcode does not use are ignored.
  always_comb begin
    w_enc = 32'h0;
    if (i_req_op) begin
      w_enc = {i_req_imm[12], i_req_imm[10:5], i_req_rs2, i_req_rs1, 3'b001,
               i_req_imm[4:1], i_req_imm[11], 7'h63};
    end else begin
      w_enc = {i_req_imm[11:0], i_req_rs1, 3'b000, i_req_rd, 7'h13};
    end
  end

`ifdef LOADER_CHECK_EN
  logic r_err;

  // addi immediate must fit in 12 signed bits; bne offset must be even.
  always_comb begin
    w_illegal = 1'b0;
    if (i_req_op) w_illegal = i_req_imm[0];
    else          w_illegal = (i_req_imm[12] != i_req_imm[11]);
  end

  // Sticky error flag, cleared by reset or by the start of a new session.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (((r_state == S_IDLE) || (r_state == S_DONE)) && i_start) begin
      r_err <= 1'b0;
    end else if (w_hs && w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_illegal = 1'b0;
  assign o_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; an illegal last request ends the session without a write.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_hs) begin
          if (w_illegal) w_next = i_req_last ? S_DONE : S_LOAD;
          else           w_next = S_WRITE;
        end
      end
      S_WRITE: w_next = (r_last || w_at_end) ? S_DONE : S_LOAD;
      S_DONE:  if (i_start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch the encoded word at handshake, count words after each write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_last  <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_hs && !w_illegal) begin
            r_wdata <= w_enc;
            r_addr  <= ADDR_W'({r_cnt, 2'b00});
            r_last  <= i_req_last;
          end
        end
        S_WRITE: begin
          r_cnt <= w_cnt_inc;
          if (!r_last && w_at_end) r_full <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state plus the held datapath registers.
  always_comb begin
    o_req_ready = (r_state == S_LOAD);
    o_mem_we    = (r_state == S_WRITE);
    o_cpu_hold  = (r_state != S_DONE);
    o_done      = (r_state == S_DONE);
    o_full      = r_full;
    o_instr_cnt = r_cnt;
    o_mem_addr  = r_addr;
    o_mem_wdata = r_wdata;
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        op = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [12:0] imm = '0;
  logic        last = 1'b0;

  logic        rdy0, we0, hold0, done0, full0, err0;
  logic [31:0] addr0, wdata0;
  logic [6:0]  cnt0;
  logic        rdy1, we1, hold1, done1, full1, err1;
  logic [31:0] addr1, wdata1;
  logic [2:0]  cnt1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t q0[$];
  wr_t q1[$];
  int  mcnt0 = 0;
  int  mcnt1 = 0;
  time t_hs = 0;

  always #5 clk = ~clk;

  instr_loader #(.AW(6), .ADDR_W(32)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_req_valid(valid0), .o_req_ready(rdy0),
    .i_req_op(op), .i_req_rd(rd), .i_req_rs1(rs1), .i_req_rs2(rs2), .i_req_imm(imm),
    .i_req_last(last), .o_mem_we(we0), .o_mem_addr(addr0), .o_mem_wdata(wdata0),
    .o_cpu_hold(hold0), .o_done(done0), .o_full(full0), .o_instr_cnt(cnt0), .o_err(err0));

  instr_loader #(.AW(2), .ADDR_W(32)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_req_valid(valid1), .o_req_ready(rdy1),
    .i_req_op(op), .i_req_rd(rd), .i_req_rs1(rs1), .i_req_rs2(rs2), .i_req_imm(imm),
    .i_req_last(last), .o_mem_we(we1), .o_mem_addr(addr1), .o_mem_wdata(wdata1),
    .o_cpu_hold(hold1), .o_done(done1), .o_full(full1), .o_instr_cnt(cnt1), .o_err(err1));

  function automatic logic [31:0] model_enc(input logic o, input logic [4:0] d, input logic [4:0] a,
                                            input logic [4:0] b, input logic [12:0] im);
    logic [31:0] w;
    if (o) begin
      w = 32'h63;
      w[7]     = im[11];
      w[11:8]  = im[4:1];
      w[14:12] = 3'd1;
      w[19:15] = a;
      w[24:20] = b;
      w[30:25] = im[10:5];
      w[31]    = im[12];
    end else begin
      w = 32'h13;
      w[11:7]  = d;
      w[19:15] = a;
      w[31:20] = im[11:0];
    end
    return w;
  endfunction

  function automatic bit model_illegal(input logic o, input logic [12:0] im);
`ifdef LOADER_CHECK_EN
    if (o) return im[0] == 1'b1;
    return im[12] != im[11];
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard for the deep instance: every write must match the oldest expectation.
  always @(negedge clk) begin
    if (we0) begin
      wr_t e;
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL d0_unexpected_write addr=%h data=%h expected no write", addr0, wdata0);
      end else begin
        e = q0.pop_front();
        if (addr0 !== e.addr || wdata0 !== e.data) begin
          failures++;
          $display("FAIL d0_write got addr=%h data=%h expected addr=%h data=%h", addr0, wdata0, e.addr, e.data);
        end
      end
    end
  end

  // Scoreboard for the 4-word instance.
  always @(negedge clk) begin
    if (we1) begin
      wr_t e;
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL d1_unexpected_write addr=%h data=%h expected no write", addr1, wdata1);
      end else begin
        e = q1.pop_front();
        if (addr1 !== e.addr || wdata1 !== e.data) begin
          failures++;
          $display("FAIL d1_write got addr=%h data=%h expected addr=%h data=%h", addr1, wdata1, e.addr, e.data);
        end
      end
    end
  end

  task automatic pulse_start(input int dut);
    if (dut == 0) begin start0 = 1'b1; mcnt0 = 0; end
    else          begin start1 = 1'b1; mcnt1 = 0; end
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Drive one request, wait (bounded) for ready, push the expected write at handshake.
  task automatic send(input int dut, input logic o, input logic [4:0] d, input logic [4:0] a,
                      input logic [4:0] b, input logic [12:0] im, input logic l, output bit ok);
    wr_t e;
    op = o; rd = d; rs1 = a; rs2 = b; imm = im; last = l;
    ok = 1'b0;
    if (dut == 0) valid0 = 1'b1; else valid1 = 1'b1;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if ((dut == 0) ? rdy0 : rdy1) begin
        ok = 1'b1;
        if (!model_illegal(o, im)) begin
          e.data = model_enc(o, d, a, b, im);
          if (dut == 0) begin e.addr = 32'(mcnt0 * 4); q0.push_back(e); mcnt0++; end
          else          begin e.addr = 32'(mcnt1 * 4); q1.push_back(e); mcnt1++; end
        end
        @(posedge clk);
        t_hs = $time;
        #1;
      end
    end
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({hold0, done0, we0, rdy0, full0, err0} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_flags got hold/done/we/rdy/full/err=%b expected 100000",
               {hold0, done0, we0, rdy0, full0, err0});
    end
    checks++;
    if (cnt0 !== 7'd0 || addr0 !== 32'd0 || wdata0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got cnt=%0d addr=%h wdata=%h expected 0 0 0", cnt0, addr0, wdata0);
    end
    checks++;
    if ({hold1, done1, we1, rdy1, full1} !== 5'b10000 || cnt1 !== 3'd0) begin
      failures++;
      $display("FAIL reset_d1 got flags=%b cnt=%0d expected 10000 0", {hold1, done1, we1, rdy1, full1}, cnt1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    pulse_start(0);
    send(0, 1'b0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_addi_ready got no ready expected ready"); end
    @(negedge clk);
    checks++;
    if (we0 !== 1'b1 || wdata0 !== 32'h00500093 || addr0 !== 32'd0) begin
      failures++;
      $display("FAIL single_addi got we=%b data=%h addr=%h expected 1 00500093 0", we0, wdata0, addr0);
    end
    send(0, 1'b1, 5'd0, 5'd1, 5'd0, 13'h1FFC, 1'b1, ok);
    @(negedge clk);
    checks++;
    if (we0 !== 1'b1 || wdata0 !== 32'hFE009EE3 || addr0 !== 32'd4) begin
      failures++;
      $display("FAIL single_bne got we=%b data=%h addr=%h expected 1 FE009EE3 4", we0, wdata0, addr0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || hold0 !== 1'b0 || cnt0 !== 7'd2 || we0 !== 1'b0 || rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL single_done got done=%b hold=%b cnt=%0d we=%b rdy=%b expected 1 0 2 0 0",
               done0, hold0, cnt0, we0, rdy0);
    end
  endtask

  task automatic test_ignored_in_done();
    int seen_rdy = 0;
    valid0 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rdy0) seen_rdy++;
    end
    valid0 = 1'b0;
    checks++;
    if (seen_rdy != 0 || done0 !== 1'b1 || cnt0 !== 7'd2) begin
      failures++;
      $display("FAIL done_ignores_req got rdy_cycles=%0d done=%b cnt=%0d expected 0 1 2", seen_rdy, done0, cnt0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad_ok = 0;
    int bad_gap = 0;
    time t_prev;
    logic [11:0] v;
    logic [12:0] im;
    logic o;
    pulse_start(0);
    for (int i = 0; i < 12; i++) begin
      o = 1'($urandom_range(0, 1));
      v = 12'($urandom);
      im = o ? (13'($urandom) & 13'h1FFE) : {v[11], v};
      t_prev = t_hs;
      send(0, o, 5'($urandom), 5'($urandom), 5'($urandom), im, (i == 11), ok);
      if (!ok) bad_ok++;
      if (i > 0 && (t_hs - t_prev) != 20) bad_gap++;
    end
    checks++;
    if (bad_ok != 0) begin failures++; $display("FAIL b2b_ready got missed=%0d expected 0", bad_ok); end
    checks++;
    if (bad_gap != 0) begin failures++; $display("FAIL b2b_throughput got bad_gaps=%0d expected 0", bad_gap); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || cnt0 !== 7'd12 || full0 !== 1'b0 || q0.size() != 0) begin
      failures++;
      $display("FAIL b2b_end got done=%b cnt=%0d full=%b pending=%0d expected 1 12 0 0",
               done0, cnt0, full0, q0.size());
    end
  endtask

  task automatic test_full();
    bit ok;
    pulse_start(1);
    for (int i = 0; i < 5; i++) begin
      send(1, 1'b0, 5'(i + 1), 5'd2, 5'd0, 13'(i * 3), 1'b0, ok);
      checks++;
      if (ok !== (i < 4)) begin
        failures++;
        $display("FAIL full_ready_req%0d got accepted=%0d expected %0d", i, ok, (i < 4));
      end
    end
    checks++;
    if (full1 !== 1'b1 || done1 !== 1'b1 || hold1 !== 1'b0 || cnt1 !== 3'd4 || q1.size() != 0) begin
      failures++;
      $display("FAIL full_state got full=%b done=%b hold=%b cnt=%0d pending=%0d expected 1 1 0 4 0",
               full1, done1, hold1, cnt1, q1.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_start(0);
    send(0, 1'b0, 5'd3, 5'd1, 5'd0, 13'd7, 1'b0, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({hold0, done0, we0, rdy0, full0, err0} !== 6'b100000 || cnt0 !== 7'd0 ||
        addr0 !== 32'd0 || wdata0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid got flags=%b cnt=%0d addr=%h wdata=%h expected 100000 0 0 0",
               {hold0, done0, we0, rdy0, full0, err0}, cnt0, addr0, wdata0);
    end
    pulse_start(0);
    send(0, 1'b0, 5'd4, 5'd4, 5'd0, 13'h1FFF, 1'b0, ok);
    @(negedge clk);
    checks++;
    if (we0 !== 1'b1 || addr0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_restart got we=%b addr=%h expected 1 0", we0, addr0);
    end
    send(0, 1'b0, 5'd5, 5'd0, 5'd0, 13'd1, 1'b1, ok);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || cnt0 !== 7'd2) begin
      failures++;
      $display("FAIL reset_mid_done got done=%b cnt=%0d expected 1 2", done0, cnt0);
    end
  endtask

  task automatic test_check();
    bit ok;
    pulse_start(0);
    send(0, 1'b0, 5'd1, 5'd0, 5'd0, 13'h0800, 1'b0, ok);
    @(negedge clk);
`ifdef LOADER_CHECK_EN
    checks++;
    if (err0 !== 1'b1 || we0 !== 1'b0 || rdy0 !== 1'b1 || cnt0 !== 7'd0) begin
      failures++;
      $display("FAIL check_illegal_addi got err=%b we=%b rdy=%b cnt=%0d expected 1 0 1 0", err0, we0, rdy0, cnt0);
    end
    send(0, 1'b0, 5'd2, 5'd0, 5'd0, 13'd9, 1'b0, ok);
    @(negedge clk);
    checks++;
    if (we0 !== 1'b1 || addr0 !== 32'd0 || wdata0 !== 32'h00900113) begin
      failures++;
      $display("FAIL check_next_legal got we=%b addr=%h data=%h expected 1 0 00900113", we0, addr0, wdata0);
    end
    send(0, 1'b1, 5'd0, 5'd2, 5'd1, 13'd3, 1'b1, ok);
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || we0 !== 1'b0 || cnt0 !== 7'd1 || err0 !== 1'b1) begin
      failures++;
      $display("FAIL check_illegal_last got done=%b we=%b cnt=%0d err=%b expected 1 0 1 1", done0, we0, cnt0, err0);
    end
`else
    checks++;
    if (we0 !== 1'b1 || wdata0 !== 32'h80000093 || addr0 !== 32'd0 || err0 !== 1'b0) begin
      failures++;
      $display("FAIL nocheck_trunc got we=%b data=%h addr=%h err=%b expected 1 80000093 0 0", we0, wdata0, addr0, err0);
    end
    send(0, 1'b1, 5'd0, 5'd2, 5'd1, 13'd3, 1'b1, ok);
    @(negedge clk);
    checks++;
    if (we0 !== 1'b1 || wdata0 !== 32'h00111163 || addr0 !== 32'd4) begin
      failures++;
      $display("FAIL nocheck_bne_odd got we=%b data=%h addr=%h expected 1 00111163 4", we0, wdata0, addr0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || cnt0 !== 7'd2 || err0 !== 1'b0) begin
      failures++;
      $display("FAIL nocheck_done got done=%b cnt=%0d err=%b expected 1 2 0", done0, cnt0, err0);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_ignored_in_done();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_check();
    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending d0=%0d d1=%0d expected 0 0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
